// File: rtl/writeback_stage_pkg.sv
// rtl/writeback_stage_pkg.sv - MIPS opcode/func constants and types shared by the W stage
package writeback_stage_pkg;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;

  // SPECIAL func codes (instr[5:0]) that write rd
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_MFHI = 6'h10;
  localparam logic [5:0] FN_MFLO = 6'h12;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  localparam logic [4:0] REG_RA = 5'd31;

  typedef enum logic [1:0] {
    WD_ALU  = 2'd0,
    WD_MEM  = 2'd1,
    WD_HILO = 2'd2,
    WD_PC8  = 2'd3
  } wd_sel_e;

  typedef enum logic [1:0] {
    DST_NONE = 2'd0,
    DST_RD   = 2'd1,
    DST_RT   = 2'd2,
    DST_RA   = 2'd3
  } dst_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc8;
    logic [31:0] alu;
    logic [31:0] dm;
    logic [31:0] hilo;
  } mw_reg_t;

endpackage

// File: rtl/writeback_stage_load_ext.sv
// rtl/writeback_stage_load_ext.sv - byte/halfword select and extension of a loaded word
// Ports: word   - aligned data-memory word (little-endian byte lanes)
//        offset - byte offset within the word (alu[1:0])
//        instr  - instruction in W; only the opcode is examined
//        value  - extended load result (word passes through for lw/non-loads)
module load_ext
  import writeback_stage_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [31:0] instr,
  output logic [31:0] value
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        unused_instr;

  assign unused_instr = ^instr[25:0];

  always_comb begin
    byte_sel = word[7:0];
    case (offset)
      2'd0: byte_sel = word[7:0];
      2'd1: byte_sel = word[15:8];
      2'd2: byte_sel = word[23:16];
      2'd3: byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase
  end

  assign half_sel = offset[1] ? word[31:16] : word[15:0];

  always_comb begin
    value = word;
    case (instr[31:26])
      OP_LB:   value = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  value = {24'd0, byte_sel};
      OP_LH:   value = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  value = {16'd0, half_sel};
      default: value = word;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - MIPS M/W pipeline register, writeback mux and register file
// Ports: clk, reset (async active-low), en (advance M/W), flush (bubble into W)
//        instr_m/pc8_m/alu_m/dm_m/hilo_m - M-stage values captured into W
//        ra1/ra2 -> rd1/rd2 - register reads with same-cycle bypass of the W write
//        instr_w, we_w, wa_w, wd_w - W instruction and its register write
//        retired - count of non-bubble instructions leaving W
module writeback_stage
  import writeback_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        flush,
  input  logic [31:0] instr_m,
  input  logic [31:0] pc8_m,
  input  logic [31:0] alu_m,
  input  logic [31:0] dm_m,
  input  logic [31:0] hilo_m,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  output logic [31:0] instr_w,
  output logic        we_w,
  output logic [4:0]  wa_w,
  output logic [31:0] wd_w,
  output logic [31:0] retired
);

  mw_reg_t     mw_q, mw_d;
  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];
  logic [31:0] retired_q, retired_d;

  dst_e        dst;
  wd_sel_e     wd_sel;
  logic [31:0] mem_val;

  always_comb begin
    mw_d = mw_q;
    if (flush) begin
      mw_d = '0;
    end else if (en) begin
      mw_d = '{instr: instr_m, pc8: pc8_m, alu: alu_m, dm: dm_m, hilo: hilo_m};
    end
  end

  assign instr_w = mw_q.instr;

  // Destination class and data source; unknown encodings fall to DST_NONE.
  always_comb begin
    dst    = DST_NONE;
    wd_sel = WD_ALU;
    case (instr_w[31:26])
      OP_SPECIAL: begin
        case (instr_w[5:0])
          FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
          FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR,
          FN_SLT, FN_SLTU: dst = DST_RD;
          FN_JALR: begin
            dst    = DST_RD;
            wd_sel = WD_PC8;
          end
          FN_MFHI, FN_MFLO: begin
            dst    = DST_RD;
            wd_sel = WD_HILO;
          end
          default: dst = DST_NONE;
        endcase
      end
      OP_JAL: begin
        dst    = DST_RA;
        wd_sel = WD_PC8;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI:
        dst = DST_RT;
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
        dst    = DST_RT;
        wd_sel = WD_MEM;
      end
      default: dst = DST_NONE;
    endcase
  end

  always_comb begin
    case (dst)
      DST_RD:  wa_w = instr_w[15:11];
      DST_RT:  wa_w = instr_w[20:16];
      DST_RA:  wa_w = REG_RA;
      default: wa_w = 5'd0;
    endcase
  end

  // $0 is never written, so the bypass and file write can trust we_w alone.
  assign we_w = (dst != DST_NONE) && (wa_w != 5'd0);

  load_ext u_load_ext (
    .word   (mw_q.dm),
    .offset (mw_q.alu[1:0]),
    .instr  (instr_w),
    .value  (mem_val)
  );

  always_comb begin
    case (wd_sel)
      WD_MEM:  wd_w = mem_val;
      WD_HILO: wd_w = mw_q.hilo;
      WD_PC8:  wd_w = mw_q.pc8;
      default: wd_w = mw_q.alu;
    endcase
  end

  // Register file writes are independent of en: a stalled W keeps rewriting
  // the same value, which is harmless.
  always_comb begin
    regs_d = regs_q;
    if (we_w) begin
      regs_d[wa_w] = wd_w;
    end
  end

  always_comb begin
    if (ra1 == 5'd0)                rd1 = 32'd0;
    else if (we_w && ra1 == wa_w)   rd1 = wd_w;
    else                            rd1 = regs_q[ra1];
  end

  always_comb begin
    if (ra2 == 5'd0)                rd2 = 32'd0;
    else if (we_w && ra2 == wa_w)   rd2 = wd_w;
    else                            rd2 = regs_q[ra2];
  end

  assign retired_d = retired_q + {31'd0, (en && instr_w != 32'd0)};
  assign retired   = retired_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mw_q      <= '0;
      retired_q <= 32'd0;
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= 32'd0;
      end
    end else begin
      mw_q      <= mw_d;
      retired_q <= retired_d;
      regs_q    <= regs_d;
    end
  end

endmodule

// File: tb/tb_writeback_stage.sv
// tb/tb_writeback_stage.sv - scoreboard bench for writeback_stage
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        flush;
  logic [31:0] instr_m, pc8_m, alu_m, dm_m, hilo_m;
  logic [4:0]  ra1, ra2;
  logic [31:0] rd1, rd2, instr_w, wd_w, retired;
  logic        we_w;
  logic [4:0]  wa_w;

  writeback_stage dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .flush   (flush),
    .instr_m (instr_m),
    .pc8_m   (pc8_m),
    .alu_m   (alu_m),
    .dm_m    (dm_m),
    .hilo_m  (hilo_m),
    .ra1     (ra1),
    .ra2     (ra2),
    .rd1     (rd1),
    .rd2     (rd2),
    .instr_w (instr_w),
    .we_w    (we_w),
    .wa_w    (wa_w),
    .wd_w    (wd_w),
    .retired (retired)
  );

  always #5 clk = ~clk;

  localparam int S_INSTR = 0, S_WE = 1, S_WA = 2, S_WD = 3, S_RD1 = 4, S_RD2 = 5, S_RET = 6;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   cycle = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always @(posedge clk) cycle++;

  function automatic logic [31:0] actual(int sel);
    case (sel)
      S_INSTR: return instr_w;
      S_WE:    return {31'd0, we_w};
      S_WA:    return {27'd0, wa_w};
      S_WD:    return wd_w;
      S_RD1:   return rd1;
      S_RD2:   return rd2;
      default: return retired;
    endcase
  endfunction

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cycle) begin
      exp_t e;
      logic [31:0] a;
      e = q.pop_front();
      a = actual(e.sel);
      n_tests++;
      if (a !== e.exp) begin
        n_fail++;
        $display("FAIL %s (cycle %0d): got 0x%08h, expected 0x%08h", e.name, e.cyc, a, e.exp);
      end
    end
  end

  task automatic expect_val(string name, int sel, logic [31:0] exp);
    q.push_back('{name: name, sel: sel, exp: exp, cyc: cycle});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rtype(logic [5:0] fn, logic [4:0] rd);
    return {6'h00, 5'd1, 5'd2, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(logic [5:0] op, logic [4:0] rt);
    return {op, 5'd3, rt, 16'h1234};
  endfunction

  initial begin
    reset = 1'b0; en = 1'b0; flush = 1'b0;
    instr_m = '0; pc8_m = '0; alu_m = '0; dm_m = '0; hilo_m = '0;
    ra1 = 5'd5; ra2 = 5'd0;
    expect_val("reset_instr_w", S_INSTR, 32'h0);
    expect_val("reset_we_w", S_WE, 32'h0);
    expect_val("reset_retired", S_RET, 32'h0);
    expect_val("reset_rd1", S_RD1, 32'h0);

    step();
    reset = 1'b1; en = 1'b1;
    instr_m = itype(6'h20, 5'd8); alu_m = 32'h2; dm_m = 32'h80FF7F01;
    expect_val("c1_retired", S_RET, 32'd0);

    step();
    n_tests++;
    if (wd_w !== 32'hFFFFFFFF) begin
      n_fail++;
      $display("FAIL direct_lb_wd: got 0x%08h", wd_w);
    end
    ra1 = 5'd8;
    expect_val("lb_wa", S_WA, 32'd8);
    expect_val("lb_wd", S_WD, 32'hFFFFFFFF);
    expect_val("lb_we", S_WE, 32'd1);
    expect_val("lb_bypass_rd1", S_RD1, 32'hFFFFFFFF);
    expect_val("lb_retired", S_RET, 32'd0);
    instr_m = itype(6'h24, 5'd9);

    step();
    ra2 = 5'd8;
    expect_val("lbu_wa", S_WA, 32'd9);
    expect_val("lbu_wd", S_WD, 32'h000000FF);
    expect_val("r8_file_rd2", S_RD2, 32'hFFFFFFFF);
    expect_val("lbu_retired", S_RET, 32'd1);
    instr_m = itype(6'h21, 5'd10); alu_m = 32'h2; dm_m = 32'h80011234;

    step();
    n_tests++;
    if (wd_w !== 32'hFFFF8001) begin
      n_fail++;
      $display("FAIL direct_lh_wd: got 0x%08h", wd_w);
    end
    expect_val("lh_wd", S_WD, 32'hFFFF8001);
    expect_val("lh_retired", S_RET, 32'd2);
    instr_m = itype(6'h25, 5'd11);

    step();
    expect_val("lhu_wd", S_WD, 32'h00008001);
    instr_m = {6'h03, 26'h100}; pc8_m = 32'h00003010; alu_m = 32'hDEAD;

    step();
    n_tests++;
    if (wa_w !== 5'd31) begin
      n_fail++;
      $display("FAIL direct_jal_wa: got %0d", wa_w);
    end
    expect_val("jal_wa", S_WA, 32'd31);
    expect_val("jal_wd", S_WD, 32'h00003010);
    expect_val("jal_we", S_WE, 32'd1);
    expect_val("jal_retired", S_RET, 32'd4);
    instr_m = rtype(6'h21, 5'd5); alu_m = 32'h1234;

    step();
    ra1 = 5'd31; ra2 = 5'd5;
    expect_val("r31_after_jal", S_RD1, 32'h00003010);
    expect_val("addu_bypass_rd2", S_RD2, 32'h00001234);
    expect_val("addu_wa", S_WA, 32'd5);
    instr_m = itype(6'h0D, 5'd0); alu_m = 32'h0000FFFF;

    step();
    ra1 = 5'd0;
    expect_val("ori_r0_we", S_WE, 32'd0);
    expect_val("r0_rd1", S_RD1, 32'd0);
    expect_val("r5_file_rd2", S_RD2, 32'h00001234);
    expect_val("ori_retired", S_RET, 32'd6);
    instr_m = itype(6'h3F, 5'd12); alu_m = 32'h55;

    step();
    ra1 = 5'd12;
    expect_val("undecoded_we", S_WE, 32'd0);
    expect_val("r12_unwritten", S_RD1, 32'd0);
    instr_m = itype(6'h09, 5'd13); alu_m = 32'h77; flush = 1'b1;

    step();
    n_tests++;
    if (instr_w !== 32'h0 || retired !== 32'd8) begin
      n_fail++;
      $display("FAIL direct_flush: instr_w 0x%08h retired %0d", instr_w, retired);
    end
    expect_val("flush_instr_w", S_INSTR, 32'h0);
    expect_val("flush_retired", S_RET, 32'd8);
    flush = 1'b0;

    step();
    expect_val("after_flush_retired", S_RET, 32'd8);
    expect_val("addiu_wd", S_WD, 32'h77);
    en = 1'b0; instr_m = itype(6'h0D, 5'd14); alu_m = 32'h99;

    step();
    n_tests++;
    if (instr_w !== itype(6'h09, 5'd13)) begin
      n_fail++;
      $display("FAIL direct_stall_instr_w: got 0x%08h", instr_w);
    end
    expect_val("stall_instr_w", S_INSTR, itype(6'h09, 5'd13));
    expect_val("stall_retired", S_RET, 32'd8);
    en = 1'b1; instr_m = rtype(6'h10, 5'd16); hilo_m = 32'hCAFEF00D; alu_m = 32'h11;

    step();
    ra1 = 5'd13;
    expect_val("mfhi_wa", S_WA, 32'd16);
    expect_val("mfhi_wd", S_WD, 32'hCAFEF00D);
    expect_val("r13_rd1", S_RD1, 32'h77);
    expect_val("mfhi_retired", S_RET, 32'd9);
    instr_m = rtype(6'h09, 5'd17); pc8_m = 32'h00004008; alu_m = 32'h22;

    step();
    expect_val("jalr_wa", S_WA, 32'd17);
    expect_val("jalr_wd", S_WD, 32'h00004008);
    instr_m = itype(6'h23, 5'd18); dm_m = 32'h13579BDF; alu_m = 32'h3;

    step();
    expect_val("lw_wd", S_WD, 32'h13579BDF);
    expect_val("lw_wa", S_WA, 32'd18);
    instr_m = rtype(6'h18, 5'd19);

    step();
    ra1 = 5'd16; ra2 = 5'd17;
    expect_val("mult_we", S_WE, 32'd0);
    expect_val("r16_rd1", S_RD1, 32'hCAFEF00D);
    expect_val("r17_rd2", S_RD2, 32'h00004008);
    expect_val("mult_retired", S_RET, 32'd12);
    instr_m = itype(6'h0F, 5'd20); alu_m = 32'hABCD0000;

    step();
    reset = 1'b0; ra1 = 5'd8; ra2 = 5'd16;
    expect_val("midreset_instr_w", S_INSTR, 32'h0);
    expect_val("midreset_we", S_WE, 32'd0);
    expect_val("midreset_retired", S_RET, 32'd0);
    expect_val("midreset_rd1", S_RD1, 32'd0);
    expect_val("midreset_rd2", S_RD2, 32'd0);

    step();
    n_tests++;
    if (retired !== 32'd0 || instr_w !== 32'h0) begin
      n_fail++;
      $display("FAIL direct_reset: retired %0d instr_w 0x%08h", retired, instr_w);
    end
    reset = 1'b1; en = 1'b0; ra1 = 5'd20; ra2 = 5'd31;
    expect_val("post_reset_r20", S_RD1, 32'd0);
    expect_val("post_reset_r31", S_RD2, 32'd0);
    expect_val("post_reset_retired", S_RET, 32'd0);

    for (int i = 0; i < 5 && q.size() > 0; i++) step();
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL %s: never checked, expected 0x%08h", e.name, e.exp);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 SHALL have clock `clk` (1, input): all state updates on its rising edge.
REQ-002 SHALL have reset `reset` (1, input): asynchronous, active-low; a low level clears all state immediately.
REQ-003 SHALL have `en` (1, input): high advances the M/W pipeline register, low holds it.
REQ-004 SHALL have `flush` (1, input): synchronous; loads a bubble into W.
REQ-005 SHALL have `instr_m` (32, input): instruction leaving the M stage.
REQ-006 SHALL have `pc8_m` (32, input): PC+8 of that instruction.
REQ-007 SHALL have `alu_m` (32, input): ALU result; bits [1:0] are the load byte offset.
REQ-008 SHALL have `dm_m` (32, input): raw aligned data-memory word.
REQ-009 SHALL have `hilo_m` (32, input): HI or LO value for mfhi/mflo.
REQ-010 SHALL have `ra1` and `ra2` (5 each, input): register-file read addresses from D.
REQ-011 SHALL have `rd1` and `rd2` (32 each, output): register-file read data.
REQ-012 SHALL have `instr_w` (32, output): registered W instruction, for the hazard unit.
REQ-013 SHALL have `we_w` (1, output): final write enable.
REQ-014 SHALL have `wa_w` (5, output): write address.
REQ-015 SHALL have `wd_w` (32, output): write data, for forwarding.
REQ-016 SHALL have `retired` (32, output): count of retired instructions.

Function
REQ-017 SHALL capture instr_m, pc8_m, alu_m, dm_m and hilo_m into the M/W register on each rising edge with en=1.
REQ-018 SHALL load all-zero into the M/W register when flush=1; flush has priority over en.
REQ-019 SHALL decode instr_w combinationally for all three destination classes:
  - R-type ALU, shift, slt/sltu, jalr, mfhi, mflo: write rd = instr_w[15:11].
  - jal: write register 31.
  - I-type ALU, lui, lw/lh/lhu/lb/lbu: write rt = instr_w[20:16].
REQ-020 SHALL select wd_w from one of four sources:
  - pc8 for jal/jalr.
  - Extended memory data for loads.
  - hilo for mfhi/mflo.
  - alu otherwise.
REQ-021 SHALL extend memory data per opcode, using offset alu_w[1:0]:
  - lw: the word.
  - lb: sign-extended byte at the offset.
  - lbu: zero-extended byte at the offset.
  - lh: sign-extended halfword selected by offset[1].
  - lhu: zero-extended halfword selected by offset[1].
REQ-022 SHALL drive we_w=1 only when instr_w is a register-writing instruction and wa_w != 0.
REQ-023 SHALL hold 32x32 general registers and write wd_w to register wa_w on the rising edge when we_w=1, independent of en.
REQ-024 SHALL return 0 for reads of register 0.
REQ-025 SHALL bypass internally on reads: rd1 = wd_w when we_w=1 and ra1 == wa_w; same rule for rd2 with ra2.
REQ-026 SHALL increment `retired` by 1 on each rising edge where en=1 and instr_w != 0; it wraps from 0xFFFFFFFF to 0.
REQ-027 SHALL treat an undecoded opcode in W as non-writing: we_w=0.

Reset
REQ-028 SHALL, while reset is low, force all of the following to 0:
  - the M/W register, so instr_w=0 (sll $0 bubble, we_w=0);
  - all 32 registers;
  - `retired`.
REQ-029 SHALL suppress any register write on the same edge that reset is asserted, including a reset asserted mid-write.

Structure
REQ-030 SHALL take opcode and func constants (op field 31:26, func field 5:0, all opcodes in REQ-019) from the shared MIPS package, together with the wd source-select encoding.
REQ-031 SHALL implement load extension in one sub-module `load_ext` (inputs: word, offset, instr; output: 32-bit value).

Verification
REQ-032 SHALL check lb: dm_m=0x80FF7F01, alu_m=0x00000002, rt=8 -> wa_w=8, wd_w=0xFFFFFFFF; lbu at the same offset -> wd_w=0x000000FF.
REQ-033 SHALL check lh: dm_m=0x8001_1234, alu_m offset 2 -> wd_w=0xFFFF8001; lhu -> 0x00008001.
REQ-034 SHALL check jal with pc8_m=0x00003010 -> wa_w=31, wd_w=0x00003010; the next cycle, ra1=31 reads 0x00003010.
REQ-035 SHALL check bypass: addu writing rd=5 with alu=0x1234 and ra2=5 in the same cycle -> rd2=0x1234 before the edge.
REQ-036 SHALL check register 0: ori with rt=0, alu=0xFFFF -> we_w=0; ra1=0 reads 0.
REQ-037 SHALL check flush, stall and reset:
  - flush=1 with en=1 -> instr_w=0 and retired unchanged next cycle.
  - en=0 -> instr_w held.
  - reset pulsed low mid-run -> all registers and retired read 0.
